// File: rtl/resp_signature_capture_if.sv
// Bundle of the capture-session control, pattern/response stream, golden-table
// write port, captured-table read port and result outputs.
interface resp_signature_capture_if #(
    parameter int N_IN  = 5,
    parameter int SIG_W = 16
);
    // pat_valid has no ready: a pair is consumed on every rising edge where it
    // is high while capturing, unless start is also high (then it is dropped).
    logic              start;
    logic              pat_valid;
    logic [N_IN-1:0]   pat;
    logic              resp;
    logic              exp_we;
    logic [N_IN-1:0]   exp_addr;
    logic              exp_bit;
    logic [N_IN-1:0]   rd_addr;
    logic              rd_resp;
    logic              busy;
    logic              done;
    logic [SIG_W-1:0]  sig;
    logic [N_IN:0]     mismatch_cnt;
    logic [N_IN-1:0]   first_fail_pat;
    logic              first_fail_vld;
    logic              order_err;

    modport master (
        output start, pat_valid, pat, resp, exp_we, exp_addr, exp_bit, rd_addr,
        input  rd_resp, busy, done, sig, mismatch_cnt, first_fail_pat,
               first_fail_vld, order_err
    );

    modport slave (
        input  start, pat_valid, pat, resp, exp_we, exp_addr, exp_bit, rd_addr,
        output rd_resp, busy, done, sig, mismatch_cnt, first_fail_pat,
               first_fail_vld, order_err
    );
endinterface

// File: rtl/resp_signature_capture.sv
// Captures single-bit DUT responses per stimulus pattern, compacts them into a
// MISR signature and compares them against a golden response table.
module resp_signature_capture #(
    parameter int               N_IN  = 5,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
    input  logic                     CK,
    input  logic                     reset,
    resp_signature_capture_if.slave  bus,
    output logic [1:0]               dbg_state_o
);
    localparam int DEPTH = 1 << N_IN;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DEPTH-1:0]  cap_q;
    logic [DEPTH-1:0]  gold_q;
    logic [SIG_W-1:0]  sig_q, sig_next;
    logic [N_IN:0]     cnt_q;
    logic [N_IN-1:0]   ffp_q;
    logic              ffv_q;
    logic              order_q;
    logic [N_IN-1:0]   exp_idx_q;
    logic              rd_resp_q;
    logic              accept;
    logic              miss;
    logic [SIG_W-1:0]  ins;

    assign accept = (state_q == S_CAPTURE) && bus.pat_valid && !bus.start;
    assign miss   = bus.resp != gold_q[bus.pat];

    always_ff @(posedge CK) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.start)
            state_d = S_CAPTURE;
        else if (accept && (bus.pat == '1))
            state_d = S_DONE;
    end

    always_comb begin
        ins = '0;
        ins[N_IN:0] = {bus.pat, bus.resp};
        sig_next = (sig_q << 1) ^ (sig_q[SIG_W-1] ? POLY : '0) ^ ins;
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            cap_q     <= '0;
            gold_q    <= '0;
            sig_q     <= SEED;
            cnt_q     <= '0;
            ffp_q     <= '0;
            ffv_q     <= 1'b0;
            order_q   <= 1'b0;
            exp_idx_q <= '0;
            rd_resp_q <= 1'b0;
        end else begin
            rd_resp_q <= cap_q[bus.rd_addr];
            if (bus.start) begin
                sig_q     <= SEED;
                cnt_q     <= '0;
                ffp_q     <= '0;
                ffv_q     <= 1'b0;
                order_q   <= 1'b0;
                exp_idx_q <= '0;
            end else if (accept) begin
                cap_q[bus.pat] <= bus.resp;
                sig_q          <= sig_next;
                exp_idx_q      <= exp_idx_q + 1'b1;
                if (bus.pat != exp_idx_q) order_q <= 1'b1;
                if (miss) begin
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    if (!ffv_q) begin
                        ffp_q <= bus.pat;
                        ffv_q <= 1'b1;
                    end
                end
            end
            // Golden table is frozen while a session is comparing against it.
            if (bus.exp_we && (state_q != S_CAPTURE))
                gold_q[bus.exp_addr] <= bus.exp_bit;
        end
    end

    assign bus.rd_resp        = rd_resp_q;
    assign bus.busy           = (state_q == S_CAPTURE);
    assign bus.done           = (state_q == S_DONE);
    assign bus.sig            = sig_q;
    assign bus.mismatch_cnt   = cnt_q;
    assign bus.first_fail_pat = ffp_q;
    assign bus.first_fail_vld = ffv_q;
    assign bus.order_err      = order_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_resp_signature_capture.sv
// Randomized and directed bench for resp_signature_capture with a behavioural
// session model and per-cycle output comparison.
module tb_resp_signature_capture;
    localparam int N_IN  = 5;
    localparam int SIG_W = 16;
    localparam int NPAT  = 32;

    logic       CK;
    logic       reset;
    logic [1:0] dbg_state;

    resp_signature_capture_if #(.N_IN(N_IN), .SIG_W(SIG_W)) bus ();

    resp_signature_capture #(
        .N_IN(N_IN), .SIG_W(SIG_W), .POLY(16'h1021), .SEED(16'hFFFF)
    ) dut (
        .CK(CK),
        .reset(reset),
        .bus(bus.slave),
        .dbg_state_o(dbg_state)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model of one capture session
    int m_gold[NPAT];
    int m_cap[NPAT];
    int m_sig, m_cnt, m_ffp, m_ffv, m_order, m_next, m_rd;
    bit m_busy, m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int misr(input int s, input int p, input int r);
        int n;
        n = (s * 2) % 65536;
        if (s >= 32768) n = n ^ 16'h1021;
        return n ^ (p * 2 + r);
    endfunction

    task automatic model_clear_session();
        m_sig = 16'hFFFF; m_cnt = 0; m_ffp = 0; m_ffv = 0; m_order = 0; m_next = 0;
    endtask

    task automatic model_apply(input bit st, input bit pv, input int p, input int r,
                               input bit we, input int ea, input int eb, input bit rst,
                               input int ra);
        int rd_new;
        if (rst) begin
            for (int i = 0; i < NPAT; i++) begin m_gold[i] = 0; m_cap[i] = 0; end
            model_clear_session();
            m_busy = 0; m_done = 0; m_rd = 0;
            return;
        end
        rd_new = m_cap[ra];
        if (we && !m_busy) m_gold[ea] = eb;
        if (st) begin
            model_clear_session();
            m_busy = 1; m_done = 0;
        end else if (m_busy && pv) begin
            m_cap[p] = r;
            m_sig = misr(m_sig, p, r);
            if (r != m_gold[p]) begin
                if (m_cnt < 63) m_cnt++;
                if (!m_ffv) begin m_ffv = 1; m_ffp = p; end
            end
            if (p != m_next) m_order = 1;
            m_next = (m_next + 1) % NPAT;
            if (p == NPAT - 1) begin m_busy = 0; m_done = 1; end
        end
        m_rd = rd_new;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".busy"}, bus.busy, m_busy);
        check({tag, ".done"}, bus.done, m_done);
        check({tag, ".sig"}, bus.sig, m_sig);
        check({tag, ".cnt"}, bus.mismatch_cnt, m_cnt);
        check({tag, ".ffv"}, bus.first_fail_vld, m_ffv);
        check({tag, ".ffp"}, bus.first_fail_pat, m_ffp);
        check({tag, ".order"}, bus.order_err, m_order);
        check({tag, ".rd_resp"}, bus.rd_resp, m_rd);
    endtask

    // Drives one cycle of inputs at the falling edge and checks after the next one.
    task automatic drive(input string tag, input bit st, input bit pv, input int p,
                         input bit r, input bit we, input int ea, input bit eb,
                         input bit rst, input int ra);
        bus.start = st; bus.pat_valid = pv; bus.pat = p[4:0]; bus.resp = r;
        bus.exp_we = we; bus.exp_addr = ea[4:0]; bus.exp_bit = eb; reset = rst;
        bus.rd_addr = ra[4:0];
        model_apply(st, pv, p, r, we, ea, eb, rst, ra);
        @(negedge CK);
        check_all(tag);
    endtask

    task automatic send(input string tag, input int p, input bit r);
        drive(tag, 0, 1, p, r, 0, 0, 0, 0, $urandom_range(0, NPAT - 1));
    endtask

    task automatic idle(input string tag, input int ra);
        drive(tag, 0, 0, 0, 0, 0, 0, 0, 0, ra);
    endtask

    task automatic do_start(input string tag);
        drive(tag, 1, 0, 0, 0, 0, 0, 0, 0, $urandom_range(0, NPAT - 1));
    endtask

    task automatic do_reset(input string tag);
        drive(tag, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        bus.start = 0; bus.pat_valid = 0; bus.pat = 0; bus.resp = 0;
        bus.exp_we = 0; bus.exp_addr = 0; bus.exp_bit = 0; bus.rd_addr = 0;
        reset = 1;
        @(negedge CK);

        // reset state
        do_reset("reset");
        check("reset.sig_seed", bus.sig, 32'hFFFF);

        // clean run, golden all zero
        do_start("clean_start");
        for (int p = 0; p < NPAT; p++) send("clean", p, 0);
        check("clean.done", bus.done, 1);
        check("clean.cnt0", bus.mismatch_cnt, 0);

        // single golden one at 5, loaded while DONE
        drive("gold5", 0, 0, 0, 0, 1, 5, 1, 0, 0);
        do_start("gold5_start");
        for (int p = 0; p < NPAT; p++) send("gold5", p, 0);
        check("gold5.cnt", bus.mismatch_cnt, 1);
        check("gold5.ffp", bus.first_fail_pat, 5);
        check("gold5.ffv", bus.first_fail_vld, 1);

        // every response wrong
        do_reset("allfail_reset");
        do_start("allfail_start");
        for (int p = 0; p < NPAT; p++) send("allfail", p, 1);
        check("allfail.cnt", bus.mismatch_cnt, 32);
        check("allfail.ffp", bus.first_fail_pat, 0);
        idle("allfail_rd17", 17);
        check("allfail.rd17", bus.rd_resp, 1);

        // out-of-order patterns 0,1,3,2,4..31
        do_reset("order_reset");
        do_start("order_start");
        send("order", 0, 0); send("order", 1, 0);
        send("order", 3, 0);
        check("order.set_after3", bus.order_err, 1);
        send("order", 2, 0);
        for (int p = 4; p < NPAT; p++) send("order", p, 0);
        check("order.done", bus.done, 1);

        // reset mid-session abandons it
        do_start("abort_start");
        for (int p = 0; p < 10; p++) send("abort", p, $urandom_range(0, 1));
        drive("abort_rst", 0, 1, 10, 1, 0, 0, 0, 1, 0);
        check("abort.sig", bus.sig, 32'hFFFF);
        check("abort.busy", bus.busy, 0);
        for (int p = 11; p < 15; p++) send("abort_ignored", p, 1);
        send("abort_ignored31", 31, 1);
        check("abort.no_done", bus.done, 0);

        // golden write attempted during capture, start+pat_valid collision
        do_start("gwr_start");
        send("gwr", 0, 0);
        drive("gwr_we", 0, 1, 1, 0, 1, 3, 1, 0, 3);
        drive("gwr_collide", 1, 1, 31, 1, 0, 0, 0, 0, 5);
        for (int p = 0; p < NPAT; p++) send("gwr", p, 0);
        check("gwr.cnt0", bus.mismatch_cnt, 0);

        // saturation of the mismatch counter
        do_start("sat_start");
        for (int i = 0; i < 70; i++) send("sat", 0, 1);
        check("sat.cnt", bus.mismatch_cnt, 63);
        send("sat_end", 31, 0);

        // randomized sessions
        for (int s = 0; s < 8; s++) begin
            int nxt;
            for (int i = 0; i < 10; i++)
                drive("rnd_gold", 0, 0, 0, 0, 1, $urandom_range(0, NPAT - 1),
                      $urandom_range(0, 1), 0, $urandom_range(0, NPAT - 1));
            do_start("rnd_start");
            nxt = 0;
            for (int c = 0; c < 150 && !m_done; c++) begin
                bit pv, st, we;
                int p;
                pv = ($urandom_range(0, 3) != 0);
                st = ($urandom_range(0, 79) == 0);
                we = ($urandom_range(0, 9) == 0);
                p  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NPAT - 1) : nxt;
                drive("rnd", st, pv, p, $urandom_range(0, 1), we,
                      $urandom_range(0, NPAT - 1), $urandom_range(0, 1), 0,
                      $urandom_range(0, NPAT - 1));
                if (st) nxt = 0;
                else if (pv) nxt = (p + 1) % NPAT;
            end
            for (int i = 0; i < 4; i++) idle("rnd_hold", $urandom_range(0, NPAT - 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/resp_signature_capture.md
RESP_SIGNATURE_CAPTURE -- requirements
Module: resp_signature_capture

Interface
REQ-001 SHALL have parameter N_IN, default 5, stimulus pattern width (N bus of the DUT).
REQ-002 SHALL have parameter SIG_W, default 16, MISR signature width; SIG_W >= N_IN+1 required.
REQ-003 SHALL have parameter POLY, default 16'h1021, MISR feedback polynomial.
REQ-004 SHALL have parameter SEED, default 16'hFFFF, MISR start value.
REQ-005 CK  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin new capture session.
REQ-008 pat_valid  input  1  pat/resp pair valid this cycle.
REQ-009 pat  input  N_IN  applied DUT stimulus.
REQ-010 resp  input  1  DUT single-bit response (output_single) for pat.
REQ-011 exp_we  input  1  golden-table write strobe.
REQ-012 exp_addr  input  N_IN  golden-table write index.
REQ-013 exp_bit  input  1  expected response for exp_addr.
REQ-014 rd_addr  input  N_IN  captured-table read index.
REQ-015 rd_resp  output  1  captured response at rd_addr, registered.
REQ-016 busy  output  1  high in CAPTURE.
REQ-017 done  output  1  high in DONE.
REQ-018 sig  output  SIG_W  MISR signature.
REQ-019 mismatch_cnt  output  N_IN+1  count of response/golden mismatches.
REQ-020 first_fail_pat  output  N_IN  pattern of first mismatch.
REQ-021 first_fail_vld  output  1  first_fail_pat is valid.
REQ-022 order_err  output  1  sticky: non-ascending pattern seen.

Function
REQ-023 SHALL implement FSM IDLE, CAPTURE, DONE; start in any state -> CAPTURE next cycle, clearing sig to SEED, mismatch_cnt, first_fail_vld, first_fail_pat, order_err, and expected-index to 0.
REQ-024 SHALL ignore pat_valid in IDLE and DONE.
REQ-025 In CAPTURE, each pat_valid cycle SHALL: write resp into captured table[pat]; update sig; compare resp with golden[pat]; all results visible the following cycle.
REQ-026 MISR update SHALL be sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended {pat, resp} (resp in LSB).
REQ-027 On mismatch SHALL increment mismatch_cnt, saturating at 2^(N_IN+1)-1; first mismatch only SHALL load first_fail_pat and set first_fail_vld.
REQ-028 Expected-index SHALL increment per accepted pair; pat != expected-index SHALL set order_err (sticky) while still capturing/comparing normally.
REQ-029 Accepting pat == all-ones SHALL move CAPTURE -> DONE next cycle, independent of order_err.
REQ-030 start and pat_valid in same cycle: start wins, pair discarded.
REQ-031 Golden-table writes SHALL take effect only in IDLE and DONE; exp_we in CAPTURE SHALL be ignored.
REQ-032 rd_resp SHALL equal captured table[rd_addr] one cycle after rd_addr, in all states.
REQ-033 DONE SHALL hold all outputs stable until start or reset.

Reset
REQ-034 reset SHALL force IDLE, busy=0, done=0, sig=SEED, mismatch_cnt=0, first_fail_pat=0, first_fail_vld=0, order_err=0, rd_resp=0.
REQ-035 reset SHALL clear captured and golden tables to 0; reset mid-CAPTURE SHALL abandon the session with no DONE.
REQ-036 reset SHALL take priority over start, pat_valid and exp_we in the same cycle.

Verification
REQ-037 Golden all 0, start, pats 0..31 with resp=0 -> done=1 one cycle after pat 31, mismatch_cnt=0, first_fail_vld=0, order_err=0, sig equals model.
REQ-038 Golden bit 5=1 only, resp all 0 -> mismatch_cnt=1, first_fail_pat=5'b00101, first_fail_vld=1.
REQ-039 Golden all 0, resp=1 for every pat 0..31 -> mismatch_cnt=32, first_fail_pat=0; rd_addr=17 -> rd_resp=1 next cycle.
REQ-040 Send pats 0,1,3 then 2,4..31 -> order_err=1 from cycle after pat 3; done still asserted after pat 31.
REQ-041 reset at pat 10 in CAPTURE -> next cycle busy=0, done=0, sig=16'hFFFF, mismatch_cnt=0; subsequent pat_valid ignored until start.
REQ-042 exp_we during CAPTURE with exp_addr=3, exp_bit=1 -> golden unchanged; resp=0 at pat 3 gives no mismatch.
